id_stage: RTL and testbench

Parametrised instruction-decode stage for the cqu_mips five-stage pipeline, placed between the IF stage and EX. It splits the instruction into fields, reads two operands from an internal register file with a write-back port, and extends the immediate. Results go into an output pipeline register with a valid/ready handshake and a flush. Operands are read in the cycle the instruction is accepted, so data and fields in the output register always belong to the same instruction.

---
 rtl/cqu_mips_pkg.sv | 34 +++
 rtl/id_regfile.sv | 54 +++++
 rtl/id_stage.sv | 211 +++++++++++++++++++++
 tb/tb_id_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cqu_mips_pkg.sv
// Shared definitions for the cqu_mips pipeline: opcode constants, instruction
// field positions and a clog2 helper usable in parameter expressions.
package cqu_mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int REGF_W     = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: two asynchronous read ports, one
// synchronous write port, register 0 hardwired to zero, asynchronous reset.
module id_regfile
    import cqu_mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [NREG];

    // Storage update; writes aimed at register 0 are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != {REG_AW{1'b0}})) begin
            mem_q[waddr] <= wdata;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Port A read, forcing zero for register 0.
    always_comb begin
        if (ra_addr == {REG_AW{1'b0}}) begin
            ra_data = {DATA_W{1'b0}};
        end else begin
            ra_data = mem_q[ra_addr];
        end
    end

    // Port B read, forcing zero for register 0.
    always_comb begin
        if (rb_addr == {REG_AW{1'b0}}) begin
            rb_data = {DATA_W{1'b0}};
        end else begin
            rb_data = mem_q[rb_addr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field split, operand read, immediate extension,
// valid/ready output register with flush. Optional macro: ID_BYPASS_EN.
module id_stage
    import cqu_mips_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int REG_AW = clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output logic [REG_AW-1:0]   rs,
    output logic [REG_AW-1:0]   rt,
    output logic [REG_AW-1:0]   rd,
    output logic [IMM_W-1:0]    imm,
    output logic [DATA_W-1:0]   imm_ext,
    output logic [DATA_W-1:0]   rs_data,
    output logic [DATA_W-1:0]   rt_data
);

    logic                accept_s;
    logic                out_valid_d;
    logic [OPCODE_W-1:0] opcode_s;
    logic [FUNCT_W-1:0]  funct_s;
    logic [REG_AW-1:0]   rs_s;
    logic [REG_AW-1:0]   rt_s;
    logic [REG_AW-1:0]   rd_s;
    logic [IMM_W-1:0]    imm_s;
    logic                ext_fill_s;
    logic [DATA_W-1:0]   imm_ext_s;
    logic [DATA_W-1:0]   rf_rs_s;
    logic [DATA_W-1:0]   rf_rt_s;
    logic [DATA_W-1:0]   rs_data_d;
    logic [DATA_W-1:0]   rt_data_d;

    logic                out_valid_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [FUNCT_W-1:0]  funct_q;
    logic [REG_AW-1:0]   rs_q;
    logic [REG_AW-1:0]   rt_q;
    logic [REG_AW-1:0]   rd_q;
    logic [IMM_W-1:0]    imm_q;
    logic [DATA_W-1:0]   imm_ext_q;
    logic [DATA_W-1:0]   rs_data_q;
    logic [DATA_W-1:0]   rt_data_q;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Register specifiers keep only the low REG_AW bits of each 5-bit field.
    assign opcode_s = instruction[OPCODE_LSB +: OPCODE_W];
    assign funct_s  = instruction[FUNCT_LSB +: FUNCT_W];
    assign rs_s     = instruction[RS_LSB +: REG_AW];
    assign rt_s     = instruction[RT_LSB +: REG_AW];
    assign rd_s     = instruction[RD_LSB +: REG_AW];
    assign imm_s    = instruction[IMM_LSB +: IMM_W];

    id_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs_s),
        .ra_data (rf_rs_s),
        .rb_addr (rt_s),
        .rb_data (rf_rt_s),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Logical immediates are zero-extended, everything else sign-extended.
    always_comb begin
        case (opcode_s)
            OP_ANDI, OP_ORI, OP_XORI: ext_fill_s = 1'b0;
            default:                  ext_fill_s = imm_s[IMM_W-1];
        endcase
    end

    // Immediate extension to the operand width.
    always_comb begin
        imm_ext_s              = {DATA_W{ext_fill_s}};
        imm_ext_s[IMM_W-1:0]   = imm_s;
    end

    // Next-state of the output valid flag; flush dominates.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

`ifdef ID_BYPASS_EN
    logic hold_s;
    assign hold_s = out_valid_q && !out_ready && !flush;

    // Operand capture with same-cycle write bypass and held-operand refresh.
    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        if (accept_s) begin
            if (wb_en && (wb_addr == rs_s) && (rs_s != {REG_AW{1'b0}})) begin
                rs_data_d = wb_data;
            end else begin
                rs_data_d = rf_rs_s;
            end
            if (wb_en && (wb_addr == rt_s) && (rt_s != {REG_AW{1'b0}})) begin
                rt_data_d = wb_data;
            end else begin
                rt_data_d = rf_rt_s;
            end
        end else if (hold_s) begin
            if (wb_en && (wb_addr == rs_q) && (rs_q != {REG_AW{1'b0}})) begin
                rs_data_d = wb_data;
            end else begin
                rs_data_d = rs_data_q;
            end
            if (wb_en && (wb_addr == rt_q) && (rt_q != {REG_AW{1'b0}})) begin
                rt_data_d = wb_data;
            end else begin
                rt_data_d = rt_data_q;
            end
        end else begin
            rs_data_d = rs_data_q;
            rt_data_d = rt_data_q;
        end
    end
`else
    // Operand capture straight from the array; the array is read before the write.
    always_comb begin
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        if (accept_s) begin
            rs_data_d = rf_rs_s;
            rt_data_d = rf_rt_s;
        end else begin
            rs_data_d = rs_data_q;
            rt_data_d = rt_data_q;
        end
    end
`endif

    // Output pipeline register; data fields load only on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            opcode_q    <= {OPCODE_W{1'b0}};
            funct_q     <= {FUNCT_W{1'b0}};
            rs_q        <= {REG_AW{1'b0}};
            rt_q        <= {REG_AW{1'b0}};
            rd_q        <= {REG_AW{1'b0}};
            imm_q       <= {IMM_W{1'b0}};
            imm_ext_q   <= {DATA_W{1'b0}};
            rs_data_q   <= {DATA_W{1'b0}};
            rt_data_q   <= {DATA_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            if (accept_s) begin
                opcode_q  <= opcode_s;
                funct_q   <= funct_s;
                rs_q      <= rs_s;
                rt_q      <= rt_s;
                rd_q      <= rd_s;
                imm_q     <= imm_s;
                imm_ext_q <= imm_ext_s;
            end else begin
                opcode_q  <= opcode_q;
                funct_q   <= funct_q;
                rs_q      <= rs_q;
                rt_q      <= rt_q;
                rd_q      <= rd_q;
                imm_q     <= imm_q;
                imm_ext_q <= imm_ext_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign funct     = funct_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign imm       = imm_q;
    assign imm_ext   = imm_ext_q;
    assign rs_data   = rs_data_q;
    assign rt_data   = rt_data_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table plus scoreboard, hand-written
// stall/flush/bypass/reset sequences, and a DATA_W=64/NREG=16 instance.
module tb_id_stage;

`ifdef ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] instruction, wb_data, imm_ext, rs_data, rt_data;
    logic [4:0]  wb_addr, rs, rt, rd;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;

    logic        iv64, ir64, fl64, we64, ov64, or64;
    logic [31:0] ins64;
    logic [3:0]  wa64, rs64, rt64, rd64;
    logic [63:0] wd64, ie64, rsd64, rtd64;
    logic [5:0]  op64, fn64;
    logic [15:0] imm64;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data)
    );

    id_stage #(.DATA_W(64), .NREG(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .instruction(ins64), .flush(fl64), .wb_en(we64), .wb_addr(wa64),
        .wb_data(wd64), .out_valid(ov64), .out_ready(or64),
        .opcode(op64), .funct(fn64), .rs(rs64), .rt(rt64), .rd(rd64), .imm(imm64),
        .imm_ext(ie64), .rs_data(rsd64), .rt_data(rtd64)
    );

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] imm_ext;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        exp_ov;
        logic        has_rs;
        logic [31:0] exp_rs;
        logic        has_imm;
        logic [31:0] exp_imm;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mregs [32];
    logic        m_ov;
    exp_t        cur;
    exp_t        sbq [$];
    vec_t        vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        e.opcode = ins[31:26];
        e.funct  = ins[5:0];
        e.rs     = ins[25:21];
        e.rt     = ins[20:16];
        e.rd     = ins[15:11];
        e.imm    = ins[15:0];
        if (ins[31:26] inside {6'h0C, 6'h0D, 6'h0E}) e.imm_ext = {16'h0000, ins[15:0]};
        else e.imm_ext = {{16{ins[15]}}, ins[15:0]};
        e.rs_data = (e.rs == 5'd0) ? 32'd0 : mregs[e.rs];
        e.rt_data = (e.rt == 5'd0) ? 32'd0 : mregs[e.rt];
        if (BYP && wb_en && wb_addr == e.rs && e.rs != 5'd0) e.rs_data = wb_data;
        if (BYP && wb_en && wb_addr == e.rt && e.rt != 5'd0) e.rt_data = wb_data;
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".opcode"},  opcode,  e.opcode);
        chk({tag, ".funct"},   funct,   e.funct);
        chk({tag, ".rs"},      rs,      e.rs);
        chk({tag, ".rt"},      rt,      e.rt);
        chk({tag, ".rd"},      rd,      e.rd);
        chk({tag, ".imm"},     imm,     e.imm);
        chk({tag, ".imm_ext"}, imm_ext, e.imm_ext);
        chk({tag, ".rs_data"}, rs_data, e.rs_data);
        chk({tag, ".rt_data"}, rt_data, e.rt_data);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_ov = 1'b0;
        sbq.delete();
    endtask

    // One clock: predict, push to scoreboard on accept, then compare after the edge.
    task automatic step(input string tag);
        logic acc, hold;
        exp_t e;
        #1;
        chk({tag, ".in_ready"}, in_ready, (!m_ov || out_ready));
        acc  = in_valid && (!m_ov || out_ready) && !flush;
        hold = m_ov && !out_ready && !flush;
        if (acc) begin
            e = model_decode(instruction);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (BYP && hold && wb_en && wb_addr == cur.rs && cur.rs != 5'd0) cur.rs_data = wb_data;
        if (BYP && hold && wb_en && wb_addr == cur.rt && cur.rt != 5'd0) cur.rt_data = wb_data;
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        m_ov = flush ? 1'b0 : (acc ? 1'b1 : (out_ready ? 1'b0 : m_ov));
        chk({tag, ".out_valid"}, out_valid, m_ov);
        if (acc) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
            end else begin
                cur = sbq.pop_front();
                cmp_out(tag, cur);
            end
        end else if (m_ov) begin
            cmp_out({tag, ".held"}, cur);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                         input logic ordy, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        in_valid = iv; instruction = ins; flush = fl; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h00A0_0020, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h3402_8000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_8000};
        vecs[5]  = '{1'b1, 32'h2002_8000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_8000};
        vecs[6]  = '{1'b1, 32'h3003_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_FFFF};
        vecs[7]  = '{1'b1, 32'h3843_8001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_8001};
        vecs[8]  = '{1'b1, 32'h3C01_8001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001};
        vecs[9]  = '{1'b1, 32'h00E7_3820, 1'b0, 1'b1, 1'b1, 5'd7, 32'hCAFE_0007, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h00E0_0020, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 32'hCAFE_0007, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

        iv64 = 1'b0; ins64 = 32'h0; fl64 = 1'b0; we64 = 1'b0; wa64 = 4'h0; wd64 = 64'h0; or64 = 1'b1;
        reset = 1'b1;
        drive(1'b1, 32'h2001_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        model_reset();
        cur = model_decode(32'h0);
        @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready",  in_ready,  1'b1);
        chk("rst.imm_ext",   imm_ext,   32'h0);
        chk("rst.rt",        rt,        5'd0);
        chk("rst.opcode",    opcode,    6'd0);
        chk("rst.rs_data",   rs_data,   32'h0);
        chk("rst.ov64",      ov64,      1'b0);

        reset = 1'b0;
        step("rel");
        chk("rel.imm_ext_const", imm_ext, 32'hFFFF_FFFF);
        chk("rel.rt_const",      rt,      5'd1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].iv, vecs[i].ins, vecs[i].fl, vecs[i].ordy,
                  vecs[i].we, vecs[i].wa, vecs[i].wd);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.ov_tab", i), out_valid, vecs[i].exp_ov);
            if (vecs[i].has_rs) chk($sformatf("vec%0d.rs_tab", i), rs_data, vecs[i].exp_rs);
            if (vecs[i].has_imm) chk($sformatf("vec%0d.imm_tab", i), imm_ext, vecs[i].exp_imm);
        end

        // Stall three cycles with a competing instruction, then flush.
        drive(1'b1, 32'h00A5_3020, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        step("stall.acc");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0025, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            step($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.rs_const", i), rs_data, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d.in_ready_const", i), in_ready, 1'b0);
        end
        drive(1'b1, 32'h3C01_BEEF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step("flush");
        chk("flush.ov_const", out_valid, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        step("flush.after");
        chk("flush.after.ov_const", out_valid, 1'b0);
        drive(1'b1, 32'h3C01_BEEF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        step("flush.idle");
        chk("flush.idle.ov_const", out_valid, 1'b0);

        // Same-cycle write versus accept, then refresh of a held operand.
        drive(1'b1, 32'h0060_0020, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0055);
        step("byp.acc");
        chk("byp.rs_const", rs_data, BYP ? 32'h0000_0055 : 32'h0);
        drive(1'b1, 32'h0003_1820, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        step("byp.rt");
        chk("byp.rt_const", rt_data, 32'h0000_0055);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0066);
        step("byp.refresh");
        chk("byp.refresh_const", rt_data, BYP ? 32'h0000_0066 : 32'h0000_0055);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step("byp.hold");

        // Asynchronous reset in the middle of a stall.
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid.out_valid", out_valid, 1'b0);
        chk("rst_mid.rt_data",   rt_data,   32'h0);
        chk("rst_mid.in_ready",  in_ready,  1'b1);
        model_reset();
        #2;
        reset = 1'b0;
        drive(1'b1, 32'h00A0_0020, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        step("rst_mid.read");
        chk("rst_mid.rs_const", rs_data, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        step("rst_mid.idle");

        // Wide instance: 64-bit operands, 4-bit register specifiers.
        we64 = 1'b1; wa64 = 4'hA; wd64 = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        we64 = 1'b0; iv64 = 1'b1; ins64 = 32'h2341_8000;
        @(posedge clk);
        #1;
        chk("w64.out_valid", ov64,  1'b1);
        chk("w64.rs",        rs64,  4'hA);
        chk("w64.rt",        rt64,  4'h1);
        chk("w64.imm_ext",   ie64,  64'hFFFF_FFFF_FFFF_8000);
        chk("w64.rs_data",   rsd64, 64'h0123_4567_89AB_CDEF);
        ins64 = 32'h3400_8000;
        @(posedge clk);
        #1;
        chk("w64.ori_ext",   ie64,  64'h0000_0000_0000_8000);
        iv64 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
